// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   op_e        : encoding of the 2-bit op field from decode
//   state_e     : sequencer FSM states
//   ITER_COUNT  : number of radix-2 iteration steps per operation
//   CNT_W       : width of the iteration counter (holds 0..ITER_COUNT)
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_DIVU  = 2'd0,
        OP_DIV   = 2'd1,
        OP_MULTU = 2'd2,
        OP_MULT  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIXUP = 2'd2
    } state_e;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT) + 1;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step: one combinational restoring-division step.
//   rem       in  : partial remainder (always < divisor for a non-zero divisor)
//   quot      in  : dividend bits still to be consumed, quotient bits so far in the LSBs
//   divisor   in  : unsigned divisor
//   rem_next  out : remainder after the trial subtract
//   quot_next out : quotient register shifted left with the new quotient bit
module div_step
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift the next dividend bit into the remainder; one extra bit keeps the
    // trial subtract exact, so diff's MSB is a clean borrow flag.
    assign shifted   = {rem, quot[WIDTH-1]};
    assign diff      = shifted - {1'b0, divisor};
    assign rem_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle controller for the HI/LO arithmetic resource.
// Runs DIV/DIVU (and MULT/MULTU when MULDIV_MULT_EN is defined) as 32 radix-2
// steps followed by a sign-fixup cycle that writes HI/LO, and services
// MTHI/MTLO while idle. Latency is 33 cycles from accept to the HI/LO write.
// Optional feature macro: MULDIV_MULT_EN (adds the shift-add multiplier).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, op         : issue an arithmetic op (0=DIVU 1=DIV 2=MULTU 3=MULT)
//   rs_val, rt_val    : dividend/multiplicand, divisor/multiplier
//   hi_we, lo_we      : MTHI / MTLO write strobes, data on wdata
//   rd_req            : MFHI/MFLO in decode
//   busy              : operation in flight
//   stall             : pipeline must hold the current HI/LO request
//   done              : one-cycle pulse after HI/LO take a result
//   hi, lo            : HI and LO registers
module muldiv_sequencer
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rs_orig;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             op_signed;
    logic             op_ok;
    logic             accept;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Signed ops work on magnitudes; the sign flags captured at accept are
    // applied once in FIXUP.
    assign op_signed = (op == OP_DIV) || (op == OP_MULT);
    assign rs_neg    = op_signed & rs_val[WIDTH-1];
    assign rt_neg    = op_signed & rt_val[WIDTH-1];
    assign rs_abs    = rs_neg ? -rs_val : rs_val;
    assign rt_abs    = rt_neg ? -rt_val : rt_val;

`ifdef MULDIV_MULT_EN
    logic               is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_abs;
    logic [2*WIDTH-1:0] prod_fix;

    // Multiply keeps the partial product in rem and the multiplier in quot;
    // each step conditionally adds the multiplicand and shifts right by one.
    assign op_ok    = 1'b1;
    assign mul_sum  = {1'b0, rem} + (quot[0] ? {1'b0, divisor} : {(WIDTH+1){1'b0}});
    assign prod_abs = {rem, quot};
    assign prod_fix = neg_res ? -prod_abs : prod_abs;
`else
    // Without the multiplier, multiply opcodes are simply not accepted.
    assign op_ok = ~op[1];
`endif

    assign accept = (state == S_IDLE) && start && op_ok;
    assign busy   = (state != S_IDLE);
    assign stall  = busy & (start | rd_req | hi_we | lo_we);

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem       (rem),
        .quot      (quot),
        .divisor   (divisor),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> ITER on accept, ITER for ITER_COUNT edges,
    // then a single FIXUP cycle back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_ITER;
            S_ITER:  if (counter == CNT_LAST) next_state = S_FIXUP;
            S_FIXUP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Final HI/LO values: quotient takes the XOR of the operand signs,
    // remainder the dividend's sign. Divide-by-zero returns all-ones and the
    // untouched dividend regardless of what the iteration produced.
    always_comb begin
        res_lo = neg_res ? -quot : quot;
        res_hi = neg_rem ? -rem : rem;
        if (div_zero) begin
            res_lo = '1;
            res_hi = rs_orig;
        end
`ifdef MULDIV_MULT_EN
        if (is_mul) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
`endif
    end

    // Datapath: MT writes and operand capture while idle, one radix-2 step
    // per ITER edge, HI/LO write plus done pulse on the FIXUP edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            counter  <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            rs_orig  <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULDIV_MULT_EN
            is_mul   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        counter  <= '0;
                        rem      <= '0;
                        quot     <= rs_abs;
                        divisor  <= rt_abs;
                        rs_orig  <= rs_val;
                        neg_res  <= rs_neg ^ rt_neg;
                        neg_rem  <= rs_neg;
                        div_zero <= (rt_val == '0);
`ifdef MULDIV_MULT_EN
                        is_mul   <= op[1];
`endif
                    end
                end
                S_ITER: begin
                    counter <= counter + CNT_W'(1);
`ifdef MULDIV_MULT_EN
                    if (is_mul) begin
                        rem  <= mul_sum[WIDTH:1];
                        quot <= {mul_sum[0], quot[WIDTH-1:1]};
                    end else begin
                        rem  <= rem_next;
                        quot <= quot_next;
                    end
`else
                    rem  <= rem_next;
                    quot <= quot_next;
`endif
                end
                S_FIXUP: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: self-checking bench for muldiv_sequencer.
// A cycle-level behavioural model computes each HI/LO result directly with
// SV arithmetic at accept time and releases it 33 edges later; a compare
// process checks every DUT output against it after each rising edge.
// Directed cases pin literal results; a randomized phase follows.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

`ifdef MULDIV_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic [1:0]   op     = 2'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         hi_we  = 1'b0;
    logic         lo_we  = 1'b0;
    logic [W-1:0] wdata  = '0;
    logic         rd_req = 1'b0;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .rd_req (rd_req),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of one HI/LO operation from plain arithmetic.
    function automatic void compute(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] rhi, output logic [W-1:0] rlo);
        int sa;
        int sb;
        longint p;
        longint unsigned up;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin
                if (b == 0) begin rlo = '1; rhi = a; end
                else begin rlo = a / b; rhi = a % b; end
            end
            2'd1: begin
                if (b == 0) begin rlo = '1; rhi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rlo = 32'h8000_0000; rhi = '0; end
                else begin rlo = W'(sa / sb); rhi = W'(sa % sb); end
            end
            2'd2: begin
                up = {32'b0, a} * {32'b0, b};
                {rhi, rlo} = up;
            end
            default: begin
                p = longint'(sa) * longint'(sb);
                {rhi, rlo} = p;
            end
        endcase
    endfunction

    // Behavioural model: result is computed at accept and becomes visible
    // 33 edges later together with a one-cycle done.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    int           m_cnt = 0;
    logic         m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start && (MULT_EN || !op[1])) begin
                    compute(op, rs_val, rt_val, p_hi, p_lo);
                    m_cnt = 33;
                end
            end
        end
    end

    task automatic check_output();
        logic m_busy;
        m_busy = (m_cnt != 0);
        check_val("busy",  W'(busy),  W'(m_busy));
        check_val("done",  W'(done),  W'(m_done));
        check_val("hi",    hi,        m_hi);
        check_val("lo",    lo,        m_lo);
        check_val("stall", W'(stall), W'(m_busy & (start | rd_req | hi_we | lo_we)));
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) check_output();
    end

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(0, 50));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic apply_stimulus();
        @(negedge clk);
        reset  = ($urandom_range(0, 499) == 0);
        start  = ($urandom_range(0, 5) == 0);
        op     = 2'($urandom_range(0, 3));
        rs_val = rand_operand();
        rt_val = rand_operand();
        hi_we  = ($urandom_range(0, 7) == 0);
        lo_we  = ($urandom_range(0, 7) == 0);
        wdata  = W'($urandom);
        rd_req = ($urandom_range(0, 3) == 0);
    endtask

    // Issue one op, then verify 33-cycle latency, literal HI/LO and a single done pulse.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int cycles;
        cycles = 0;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; rs_val = W'($urandom); rt_val = W'($urandom);
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_val({name, " latency"}, W'(cycles), W'(33));
        check_val({name, " lo"}, lo, elo);
        check_val({name, " hi"}, hi, ehi);
        @(posedge clk); #1;
        check_val({name, " done pulse width"}, W'(done), W'(0));
    endtask

    initial begin
        logic [W-1:0] th;
        logic [W-1:0] tl;
        int cycles;
        int pulses;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset busy", W'(busy), W'(0));
        check_val("reset done", W'(done), W'(0));
        check_val("reset hi", hi, W'(0));
        check_val("reset lo", lo, W'(0));
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        compute(OP_DIV, 32'hFFFF_FFD7, 32'd20, th, tl);
        check_val("model div lo", tl, 32'hFFFF_FFFE);
        check_val("model div hi", th, 32'hFFFF_FFFF);
        compute(OP_DIVU, 32'hFFFF_FFD7, 32'd20, th, tl);
        check_val("model divu lo", tl, 32'h0CCC_CCCA);
        check_val("model divu hi", th, 32'h0000_000F);

        run_op("div neg", OP_DIV,  32'hFFFF_FFD7, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("divu",    OP_DIVU, 32'hFFFF_FFD7, 32'd20, 32'h0000_000F, 32'h0CCC_CCCA);
        run_op("div by 0", OP_DIV, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Busy: MFHI stalls, MTHI is ignored, result still lands.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rd_req = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
        #1;
        check_val("busy stall", W'(stall), W'(1));
        check_val("busy hi hold", hi, 32'h0000_0000);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_val("busy result lo", lo, 32'd14);
        check_val("busy result hi", hi, 32'd2);
        check_val("stall after done", W'(stall), W'(0));
        @(negedge clk);
        rd_req = 1'b0; hi_we = 1'b0;

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("abort busy", W'(busy), W'(0));
        check_val("abort hi", hi, W'(0));
        check_val("abort lo", lo, W'(0));
        check_val("abort done", W'(done), W'(0));
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check_val("abort no done", W'(pulses), W'(0));
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        check_val("mtlo idle", lo, 32'h0000_ABCD);
        @(negedge clk);
        lo_we = 1'b0;

`ifdef MULDIV_MULT_EN
        run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        @(negedge clk);
        start = 1'b1; op = OP_MULT; rs_val = 32'hFFFF_FFFF; rt_val = 32'd3;
        @(posedge clk); #1;
        check_val("mult off busy", W'(busy), W'(0));
        check_val("mult off hi", hi, 32'h0000_0000);
        check_val("mult off lo", lo, 32'h0000_ABCD);
        @(negedge clk);
        start = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) apply_stimulus();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; rd_req = 1'b0;
        repeat (40) @(posedge clk);
        #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
